// File: rtl/uart_pkg.sv
// Shared constants, the assembler state type and a byte-lane insert helper
// for the UART word packer.
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int NBYTES_W       = 3;
  localparam int FIFO_W         = WORD_W + NBYTES_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } asm_state_t;

  // Byte idx of a word occupies bits [8*idx+7 : 8*idx] (LSB-first packing).
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0]   word,
    input logic [7:0]          b,
    input logic [NBYTES_W-1:0] idx
  );
    logic [WORD_W-1:0] r;
    r = word;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (idx == NBYTES_W'(k)) r[8*k +: 8] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// First-word fall-through FIFO of {nbytes, word} entries with an occupancy
// count register; pointers wrap modulo DEPTH.
module uart_word_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FIFO_W-1:0] wdata,
  input  logic              pop,
  output logic [FIFO_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [FIFO_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // push that coincides with a pop. Pops on an empty FIFO are dropped.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so stale entries never show on q.
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes into 32-bit words (one byte per word in normal mode, four
// in burst mode) and queues them. Optional idle timeout: UART_RX_WORD_TIMEOUT_EN.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 160
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_byte,
  input  logic                rx_dv,
  input  logic                mode,
  input  logic                flush,
  input  logic                rd,
  output logic [WORD_W-1:0]   q,
  output logic [NBYTES_W-1:0] q_nbytes,
  output logic                valid,
  output logic                ovf,
  input  logic                clr_ovf,
  output asm_state_t          dbg_state
);

  // Handshake: no back-pressure on the byte side (rx_dv/flush are strobes
  // that are always taken); on the word side valid means q is the head and
  // rd pops it that cycle; a push into a full FIFO without rd is dropped.

  asm_state_t          state;
  logic [NBYTES_W-1:0] cnt;
  logic [WORD_W-1:0]   acc;
  logic                eff_mode;
  logic                cur_mode;
  logic                timeout_hit;

  logic [WORD_W-1:0]   app_word;
  logic [NBYTES_W-1:0] app_cnt;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic [NBYTES_W-1:0] push_nb;
  logic [NBYTES_W-1:0] nxt_cnt;
  logic [WORD_W-1:0]   nxt_acc;

  logic [FIFO_W-1:0]   fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;

  // The mode input only matters at a word boundary; mid-word the latched
  // mode keeps the current word's packing.
  assign cur_mode = (cnt == '0) ? mode : eff_mode;

`ifdef UART_RX_WORD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr;

  // tmr counts idle cycles already elapsed; this cycle is idle number tmr+1.
  assign timeout_hit = (state == FILL) && (tmr == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    app_word  = insert_byte(acc, rx_byte, cnt);
    app_cnt   = cnt + 1'b1;
    push      = 1'b0;
    push_word = acc;
    push_nb   = cnt;
    nxt_cnt   = cnt;
    nxt_acc   = acc;
    if (rx_dv) begin
      nxt_cnt = app_cnt;
      nxt_acc = app_word;
      // A byte arriving with flush is appended first, then the word goes out.
      if (!cur_mode || flush || (app_cnt == NBYTES_W'(BYTES_PER_WORD))) begin
        push      = 1'b1;
        push_word = app_word;
        push_nb   = app_cnt;
      end
    end else if ((cnt != '0) && (flush || timeout_hit)) begin
      push = 1'b1;
    end
    if (push) begin
      nxt_cnt = '0;
      nxt_acc = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      eff_mode <= 1'b0;
`ifdef UART_RX_WORD_TIMEOUT_EN
      tmr      <= '0;
`endif
    end else begin
      cnt   <= nxt_cnt;
      acc   <= nxt_acc;
      state <= (nxt_cnt == '0) ? IDLE : FILL;
      if (cnt == '0) eff_mode <= mode;
`ifdef UART_RX_WORD_TIMEOUT_EN
      if (rx_dv || (nxt_cnt == '0)) tmr <= '0;
      else if (state == FILL)       tmr <= tmr + 1'b1;
`endif
    end
  end

  // Overrun: set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push && fifo_full && !rd) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  uart_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({push_nb, push_word}),
    .pop   (rd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign q         = fifo_rdata[WORD_W-1:0];
  assign q_nbytes  = fifo_rdata[FIFO_W-1:WORD_W];
  assign valid     = !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer: directed scenarios plus a
// randomized run against a byte-list/word-queue reference model.
module tb_uart_rx_word_packer;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_dv = 1'b0;
  logic        mode = 1'b0;
  logic        flush = 1'b0;
  logic        rd = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [31:0] q;
  logic [2:0]  q_nbytes;
  logic        valid;
  logic        ovf;
  asm_state_t  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending bytes of the word being built, the mode that
  // word was started in, the expected FIFO contents {nbytes, word}, ovf.
  logic [7:0]  m_pend[$];
  logic        m_em;
  logic [34:0] exp_q[$];
  logic        m_ovf;
  int          m_idle;

  uart_rx_word_packer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_dv     (rx_dv),
    .mode      (mode),
    .flush     (flush),
    .rd        (rd),
    .q         (q),
    .q_nbytes  (q_nbytes),
    .valid     (valid),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic model_clear();
    m_pend.delete();
    exp_q.delete();
    m_em   = 1'b0;
    m_ovf  = 1'b0;
    m_idle = 0;
  endtask

  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  function automatic logic [34:0] pack_pending();
    logic [31:0] w;
    w = 0;
    for (int k = 0; k < m_pend.size(); k++) w = w + (32'(m_pend[k]) << (8 * k));
    return {3'(m_pend.size()), w};
  endfunction

  task automatic model_step(input logic dv, input logic [7:0] b,
                            input logic fl, input logic r, input logic clr);
    logic do_pop, do_push, overrun;
    logic [34:0] w;
    do_pop  = r && (exp_q.size() > 0);
    do_push = 1'b0;
    w       = '0;
    if (dv) begin
      if (m_pend.size() == 0) m_em = mode;
      m_pend.push_back(b);
      m_idle = 0;
      if (!m_em || fl || m_pend.size() == 4) do_push = 1'b1;
    end else if (m_pend.size() > 0) begin
      m_idle++;
      if (fl) do_push = 1'b1;
`ifdef UART_RX_WORD_TIMEOUT_EN
      if (m_idle == TMO) do_push = 1'b1;
`endif
    end
    if (do_push) begin
      w = pack_pending();
      m_pend.delete();
      m_idle = 0;
    end
    overrun = do_push && (exp_q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push && !overrun) exp_q.push_back(w);
    if (overrun) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic dv, input logic [7:0] b, input logic fl,
                       input logic r, input logic clr);
    rx_dv   = dv;
    rx_byte = b;
    flush   = fl;
    rd      = r;
    clr_ovf = clr;
    model_step(dv, b, fl, r, clr);
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
    flush   = 1'b0;
    rd      = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mode = 1'b1;
    send(8'hA1);
    send(8'hA2);
    mode = 1'b0;
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if ({valid, ovf, q_nbytes, q} !== 37'd0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_async: valid=%0b ovf=%0b nb=%0d q=%h st=%0d, required all zero",
               valid, ovf, q_nbytes, q, dbg_state);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: valid=%0b after flush, required 0", valid);
    end
  endtask

  task automatic test_normal();
    apply_reset();
    mode = 1'b0;
    send(8'h41);
    n_checks++;
    if (valid !== 1'b1 || q !== 32'h00000041 || q_nbytes !== 3'd1) begin
      n_fail++;
      $display("FAIL normal_first: valid=%0b q=%h nb=%0d, required 1 00000041 1", valid, q, q_nbytes);
    end
    send(8'h42);
    pop();
    n_checks++;
    if (valid !== 1'b1 || q !== 32'h00000042 || q_nbytes !== 3'd1) begin
      n_fail++;
      $display("FAIL normal_second: valid=%0b q=%h nb=%0d, required 1 00000042 1", valid, q, q_nbytes);
    end
    pop();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_drain: valid=%0b, required 0", valid);
    end
    pop();
    n_checks++;
    if (valid !== 1'b0 || q !== 32'd0) begin
      n_fail++;
      $display("FAIL empty_rd: valid=%0b q=%h, required 0 00000000", valid, q);
    end
  endtask

  task automatic test_burst();
    apply_reset();
    mode = 1'b1;
    send(8'h41);
    send(8'h42);
    send(8'h43);
    n_checks++;
    if (valid !== 1'b0 || dbg_state !== FILL) begin
      n_fail++;
      $display("FAIL burst_partial: valid=%0b st=%0d, required 0 FILL", valid, dbg_state);
    end
    send(8'h44);
    n_checks++;
    if (valid !== 1'b1 || q !== 32'h44434241 || q_nbytes !== 3'd4 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL burst_word: valid=%0b q=%h nb=%0d st=%0d, required 1 44434241 4 IDLE",
               valid, q, q_nbytes, dbg_state);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    mode = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: valid=%0b, required 0", valid);
    end
    send(8'h5A);
    send(8'h5B);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valid !== 1'b1 || q !== 32'h00005B5A || q_nbytes !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_word: valid=%0b q=%h nb=%0d, required 1 00005b5a 2", valid, q, q_nbytes);
    end
    pop();
    send(8'h11);
    cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valid !== 1'b1 || q !== 32'h00002211 || q_nbytes !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_with_dv: valid=%0b q=%h nb=%0d, required 1 00002211 2", valid, q, q_nbytes);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    mode = 1'b1;
    send(8'h5A);
    send(8'h5B);
`ifdef UART_RX_WORD_TIMEOUT_EN
    n = 0;
    while (!valid && n < TMO + 20) begin
      idle(1);
      n++;
    end
    n_checks++;
    if (n !== TMO || q !== 32'h00005B5A || q_nbytes !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_push: after %0d idle q=%h nb=%0d, required %0d 00005b5a 2",
               n, q, q_nbytes, TMO);
    end
`else
    n = TMO + 40;
    idle(n);
    n_checks++;
    if (valid !== 1'b0 || dbg_state !== FILL) begin
      n_fail++;
      $display("FAIL no_timeout: valid=%0b st=%0d after %0d idle, required 0 FILL", valid, dbg_state, n);
    end
`endif
  endtask

  task automatic test_overrun();
    apply_reset();
    mode = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early: ovf=%0b when just full, required 0", ovf);
    end
    send(8'h05);
    n_checks++;
    if (ovf !== 1'b1 || q !== 32'h00000001) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%0b head=%h, required 1 00000001", ovf, q);
    end
    cycle(1'b1, 8'h06, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%0b, required 1", ovf);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%0b, required 0", ovf);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (valid !== 1'b1 || q !== 32'(i) || q_nbytes !== 3'd1) begin
        n_fail++;
        $display("FAIL ovf_contents[%0d]: valid=%0b q=%h nb=%0d, required 1 %h 1", i, valid, q, q_nbytes, 32'(i));
      end
      pop();
    end
  endtask

  task automatic test_full_rd();
    logic [31:0] want [4];
    want = '{32'h02, 32'h03, 32'h04, 32'h05};
    apply_reset();
    mode = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    cycle(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ovf !== 1'b0 || q !== 32'h00000002) begin
      n_fail++;
      $display("FAIL full_rd: ovf=%0b head=%h, required 0 00000002", ovf, q);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (valid !== 1'b1 || q !== want[i]) begin
        n_fail++;
        $display("FAIL full_rd_order[%0d]: valid=%0b q=%h, required 1 %h", i, valid, q, want[i]);
      end
      pop();
    end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    mode = 1'b1;
    send(8'h11);
    send(8'h22);
    mode = 1'b0;
    send(8'h33);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_hold: valid=%0b mid-word, required 0", valid);
    end
    send(8'h44);
    send(8'h55);
    n_checks++;
    if (q !== 32'h44332211 || q_nbytes !== 3'd4) begin
      n_fail++;
      $display("FAIL mode_word: q=%h nb=%0d, required 44332211 4", q, q_nbytes);
    end
    pop();
    n_checks++;
    if (valid !== 1'b1 || q !== 32'h00000055 || q_nbytes !== 3'd1) begin
      n_fail++;
      $display("FAIL mode_after: valid=%0b q=%h nb=%0d, required 1 00000055 1", valid, q, q_nbytes);
    end
  endtask

  task automatic test_random();
    logic [34:0] exp_head;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      cycle(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 19) == 0));
      exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
      n_checks++;
      if (valid !== (exp_q.size() > 0) || {q_nbytes, q} !== exp_head || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%0b nb=%0d q=%h ovf=%0b, required %0b %0d %h %0b",
                 i, valid, q_nbytes, q, ovf, (exp_q.size() > 0), exp_head[34:32], exp_head[31:0], m_ovf);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    model_clear();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_normal();
    test_burst();
    test_flush();
    test_timeout();
    test_overrun();
    test_full_rd();
    test_mode_switch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
